// File: rtl/enc_bundler_pack.sv
// Bundles NUM_BEATS beats of HVS_PER_BEAT sparse HVs into one thresholded HV.
// Per-bit popcounts accumulate in ACCUM and are thresholded in a single THRESH cycle.
module enc_bundler_pack #(
  parameter int HV_DIM       = 1024,
  parameter int HVS_PER_BEAT = 10,
  parameter int NUM_BEATS    = 4,
  parameter int THRESHOLD    = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] shifted_hv [0:HVS_PER_BEAT-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] bundled_hv,
  output logic              busy
);

  localparam int CW = $clog2(HVS_PER_BEAT*NUM_BEATS+1);
  localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS-1);
  localparam logic [31:0]   THR32     = 32'(THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_THRESH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CW-1:0]     r_cnt [HV_DIM];
  logic [CW-1:0]     w_cnt_next [HV_DIM];
  logic [BW-1:0]     r_beat_cnt;
  logic [HV_DIM-1:0] r_bundled;
  logic [HV_DIM-1:0] w_thresh;
  logic [CW:0]       w_acc;
  logic              w_accept;
  logic              w_clear;

  assign w_accept   = (r_state == S_ACCUM) && in_valid;
  assign w_clear    = (r_state == S_IDLE) && start;
  assign in_ready   = (r_state == S_ACCUM);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign bundled_hv = r_bundled;

  // State register
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_ACCUM;
        else       w_next_state = S_IDLE;
      end
      S_ACCUM: begin
        if (w_accept && (r_beat_cnt == LAST_BEAT)) w_next_state = S_THRESH;
        else                                       w_next_state = S_ACCUM;
      end
      S_THRESH: w_next_state = S_DONE;
      S_DONE: begin
        if (out_ready) w_next_state = S_IDLE;
        else           w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Per-bit column popcount added to the running count, saturating at CNT_MAX
  always_comb begin
    w_acc = '0;
    for (int b = 0; b < HV_DIM; b++) begin
      w_acc = {1'b0, r_cnt[b]};
      for (int i = 0; i < HVS_PER_BEAT; i++) begin
        w_acc = w_acc + {{CW{1'b0}}, shifted_hv[i][b]};
      end
      if (w_acc > {1'b0, CNT_MAX}) w_cnt_next[b] = CNT_MAX;
      else                         w_cnt_next[b] = w_acc[CW-1:0];
      w_thresh[b] = (32'(r_cnt[b]) >= THR32);
    end
  end

  // Counters, beat index and thresholded bundle
  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int b = 0; b < HV_DIM; b++) r_cnt[b] <= '0;
      r_beat_cnt <= '0;
      r_bundled  <= '0;
    end else begin
      if (w_clear) begin
        for (int b = 0; b < HV_DIM; b++) r_cnt[b] <= '0;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        for (int b = 0; b < HV_DIM; b++) r_cnt[b] <= w_cnt_next[b];
        r_beat_cnt <= r_beat_cnt + BW'(1);
      end else begin
        r_beat_cnt <= r_beat_cnt;
      end
      // bundled_hv only changes in THRESH so it stays stable through DONE and IDLE
      if (r_state == S_THRESH) r_bundled <= w_thresh;
      else                     r_bundled <= r_bundled;
    end
  end

endmodule

// File: tb/tb_enc_bundler_pack.sv
// Directed self-checking bench for enc_bundler_pack; extra instances cover
// THRESHOLD = 0, 40 and 41 with the same stimulus.
module tb_enc_bundler_pack;

  localparam int HV_DIM = 256;
  localparam int HVS    = 10;

  logic              clk;
  logic              nrst;
  logic              start;
  logic              in_valid;
  logic              out_ready;
  logic [HV_DIM-1:0] hv [0:HVS-1];

  logic              rdy_a, ov_a, busy_a;
  logic [HV_DIM-1:0] bh_a;
  logic              rdy_0, ov_0, busy_0;
  logic [HV_DIM-1:0] bh_0;
  logic              rdy_40, ov_40, busy_40;
  logic [HV_DIM-1:0] bh_40;
  logic              rdy_41, ov_41, busy_41;
  logic [HV_DIM-1:0] bh_41;

  int checks   = 0;
  int failures = 0;

  logic [HV_DIM-1:0] ones;
  logic [HV_DIM-1:0] zeros;

  enc_bundler_pack #(.HV_DIM(HV_DIM), .HVS_PER_BEAT(HVS), .NUM_BEATS(4), .THRESHOLD(2)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
    .shifted_hv(hv), .out_valid(ov_a), .out_ready(out_ready), .bundled_hv(bh_a), .busy(busy_a));

  enc_bundler_pack #(.HV_DIM(HV_DIM), .HVS_PER_BEAT(HVS), .NUM_BEATS(4), .THRESHOLD(0)) u_dut_t0 (
    .clk(clk), .nrst(nrst), .start(start), .in_valid(in_valid), .in_ready(rdy_0),
    .shifted_hv(hv), .out_valid(ov_0), .out_ready(out_ready), .bundled_hv(bh_0), .busy(busy_0));

  enc_bundler_pack #(.HV_DIM(HV_DIM), .HVS_PER_BEAT(HVS), .NUM_BEATS(4), .THRESHOLD(40)) u_dut_t40 (
    .clk(clk), .nrst(nrst), .start(start), .in_valid(in_valid), .in_ready(rdy_40),
    .shifted_hv(hv), .out_valid(ov_40), .out_ready(out_ready), .bundled_hv(bh_40), .busy(busy_40));

  enc_bundler_pack #(.HV_DIM(HV_DIM), .HVS_PER_BEAT(HVS), .NUM_BEATS(4), .THRESHOLD(41)) u_dut_t41 (
    .clk(clk), .nrst(nrst), .start(start), .in_valid(in_valid), .in_ready(rdy_41),
    .shifted_hv(hv), .out_valid(ov_41), .out_ready(out_ready), .bundled_hv(bh_41), .busy(busy_41));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [HV_DIM-1:0] got, input logic [HV_DIM-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HV_DIM-1:0] bit_hv(input int k);
    logic [HV_DIM-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic clear_hv;
    for (int i = 0; i < HVS; i++) hv[i] = '0;
  endtask

  task automatic fill_hv(input logic [HV_DIM-1:0] v);
    for (int i = 0; i < HVS; i++) hv[i] = v;
  endtask

  task automatic send_beat;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    ones  = '1;
    zeros = '0;
    nrst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clear_hv();
    tick(); tick();
    nrst = 1'b0;
    check_val("rst_in_ready", HV_DIM'(rdy_a), HV_DIM'(1'b0));
    check_val("rst_out_valid", HV_DIM'(ov_a), HV_DIM'(1'b0));
    check_val("rst_bundled", bh_a, zeros);
    check_val("rst_busy", HV_DIM'(busy_a), HV_DIM'(1'b0));

    // Reset mid-ACCUM after two all-ones beats
    do_start();
    fill_hv(ones);
    send_beat(); send_beat();
    clear_hv();
    check_val("t1_busy_accum", HV_DIM'(busy_a), HV_DIM'(1'b1));
    nrst = 1'b1; tick(); tick(); nrst = 1'b0;
    check_val("t1_in_ready", HV_DIM'(rdy_a), HV_DIM'(1'b0));
    check_val("t1_out_valid", HV_DIM'(ov_a), HV_DIM'(1'b0));
    check_val("t1_bundled", bh_a, zeros);
    check_val("t1_busy", HV_DIM'(busy_a), HV_DIM'(1'b0));

    // Bit 5 in HV0 and HV1 on every beat; count 8
    do_start();
    check_val("t2_in_ready", HV_DIM'(rdy_a), HV_DIM'(1'b1));
    hv[0] = bit_hv(5); hv[1] = bit_hv(5);
    in_valid = 1'b1;
    tick(); tick(); tick();
    check_val("t2_ready_after3", HV_DIM'(rdy_a), HV_DIM'(1'b1));
    tick();
    in_valid = 1'b0;
    clear_hv();
    check_val("t2_thresh_ov", HV_DIM'(ov_a), HV_DIM'(1'b0));
    check_val("t2_thresh_rdy", HV_DIM'(rdy_a), HV_DIM'(1'b0));
    check_val("t2_thresh_busy", HV_DIM'(busy_a), HV_DIM'(1'b1));
    tick();
    check_val("t2_out_valid", HV_DIM'(ov_a), HV_DIM'(1'b1));
    check_val("t2_bundled", bh_a, bit_hv(5));
    handshake();
    check_val("t2_ov_drop", HV_DIM'(ov_a), HV_DIM'(1'b0));
    check_val("t2_idle", HV_DIM'(busy_a), HV_DIM'(1'b0));
    check_val("t2_retained", bh_a, bit_hv(5));

    // Threshold edge: bit7 count 2, bit9 count 1
    do_start();
    hv[0] = bit_hv(7); hv[1] = bit_hv(7);
    send_beat();
    clear_hv();
    send_beat(); send_beat();
    hv[4] = bit_hv(9);
    send_beat();
    clear_hv();
    tick();
    check_val("t3_out_valid", HV_DIM'(ov_a), HV_DIM'(1'b1));
    check_val("t3_bundled", bh_a, bit_hv(7));
    check_val("t3_thr0_ones", bh_0, ones);
    handshake();

    // in_valid gaps carrying bit 20, then DONE held with out_ready low
    do_start();
    for (int k = 0; k < 4; k++) begin
      fill_hv(bit_hv(20));
      tick(); tick();
      check_val("t4_gap_ready", HV_DIM'(rdy_a), HV_DIM'(1'b1));
      clear_hv();
      hv[0] = bit_hv(10); hv[1] = bit_hv(10);
      send_beat();
    end
    clear_hv();
    check_val("t4_thresh_rdy", HV_DIM'(rdy_a), HV_DIM'(1'b0));
    tick();
    for (int k = 0; k < 5; k++) begin
      check_val("t4_hold_ov", HV_DIM'(ov_a), HV_DIM'(1'b1));
      check_val("t4_hold_hv", bh_a, bit_hv(10));
      tick();
    end
    handshake();
    check_val("t4_idle", HV_DIM'(busy_a), HV_DIM'(1'b0));
    check_val("t4_ov_drop", HV_DIM'(ov_a), HV_DIM'(1'b0));

    // start in ACCUM/DONE and in_valid in THRESH/DONE are ignored
    do_start();
    hv[0] = bit_hv(40); hv[1] = bit_hv(40);
    send_beat();
    clear_hv();
    do_start();
    check_val("t5_start_accum", HV_DIM'(rdy_a), HV_DIM'(1'b1));
    send_beat(); send_beat(); send_beat();
    fill_hv(ones);
    in_valid = 1'b1;
    check_val("t5_thresh_rdy", HV_DIM'(rdy_a), HV_DIM'(1'b0));
    tick();
    do_start();
    check_val("t5_done_ov", HV_DIM'(ov_a), HV_DIM'(1'b1));
    check_val("t5_done_rdy", HV_DIM'(rdy_a), HV_DIM'(1'b0));
    check_val("t5_done_hv", bh_a, bit_hv(40));
    tick();
    check_val("t5_done_hv2", bh_a, bit_hv(40));
    in_valid = 1'b0;
    clear_hv();
    handshake();
    check_val("t5_idle", HV_DIM'(busy_a), HV_DIM'(1'b0));

    // start with in_valid in IDLE: that beat (bit 30) is not consumed
    hv[0] = bit_hv(30); hv[1] = bit_hv(30); hv[2] = bit_hv(30);
    in_valid = 1'b1;
    do_start();
    in_valid = 1'b0;
    clear_hv();
    hv[0] = bit_hv(50); hv[1] = bit_hv(50);
    send_beat(); send_beat(); send_beat();
    check_val("t5_sv_ready", HV_DIM'(rdy_a), HV_DIM'(1'b1));
    send_beat();
    clear_hv();
    tick();
    check_val("t5_sv_hv", bh_a, bit_hv(50));
    handshake();

    // All-ones for 4 beats: count 40 everywhere
    do_start();
    fill_hv(ones);
    send_beat(); send_beat(); send_beat(); send_beat();
    clear_hv();
    tick();
    check_val("t6_default", bh_a, ones);
    check_val("t6_thr40", bh_40, ones);
    check_val("t6_thr41", bh_41, zeros);
    check_val("t6_thr41_ov", HV_DIM'(ov_41), HV_DIM'(1'b1));
    handshake();
    check_val("t6_idle", HV_DIM'(busy_40), HV_DIM'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
